// File: rtl/img_pkg.sv
// Shared definitions for the image-receive controller: state encoding,
// default frame geometry, sync byte and pixel/address widths.
package img_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX_HI     = 4'd1,
    ST_RX_LO     = 4'd2,
    ST_WAIT_TAIL = 4'd3
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'h5A;
  localparam int unsigned PIX_W           = 12;
  localparam int unsigned ADDR_W          = 15;
  localparam int unsigned IMG_W           = 160;
  localparam int unsigned IMG_H           = 120;
  localparam int unsigned PIX_NUM_DEF     = IMG_W * IMG_H;
  localparam int unsigned TIMEOUT_CYC_DEF = 500_000;

  // RGB444 pixel: low nibble of the first byte, then the full second byte.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [3:0] hi,
                                                   input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/img_rx_timeout.sv
// Inter-byte idle counter. Loads zero on clear, counts while enabled and
// flags expiry on the cycle whose increment would reach TIMEOUT_CYC.
module img_rx_timeout #(
  parameter int unsigned TIMEOUT_CYC = 500_000
) (
  input  logic i_clk_sys,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned      CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_term;

  assign at_term = (cnt_q == TERM);
  // A byte arriving on the terminal cycle takes precedence over expiry.
  assign o_expired = i_en && !i_clear && at_term;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_en && !at_term) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so all flops update together at the edge.
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/img_rx_ctrl.sv
// Image-receive controller: finds the sync header, assembles byte pairs into
// RGB444 pixels with sequential write addresses, and swaps the write/display
// bank only when a frame ends with a valid trailer.
module img_rx_ctrl
  import img_pkg::*;
#(
  parameter int unsigned PIX_NUM     = PIX_NUM_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              i_clk_sys,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rcv_data,
  input  logic              i_rcv_flag,
  output logic [PIX_W-1:0]  o_pix_data,
  output logic              o_pix_valid,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic              o_buf_sel,
  output logic              o_frame_done,
  output logic              o_err,
  output logic              o_receiving,
  output logic [3:0]        o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_NUM - 1);

  state_e             state_q;
  logic [3:0]         hi_q;
  logic [ADDR_W-1:0]  pix_cnt_q;
  logic [PIX_W-1:0]   pix_data_q;
  logic [ADDR_W-1:0]  pix_addr_q;
  logic               pix_valid_q;
  logic               buf_sel_q;
  logic               frame_done_q;
  logic               err_q;
  logic               receiving_q;

  logic               tmo_clear;
  logic               tmo_en;
  logic               tmo_expired;

  // The idle counter only runs inside a frame; every byte restarts it.
  assign tmo_clear = i_rcv_flag || (state_q == ST_IDLE);
  assign tmo_en    = (state_q != ST_IDLE);

  img_rx_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk_sys (i_clk_sys),
    .i_rst_n   (i_rst_n),
    .i_clear   (tmo_clear),
    .i_en      (tmo_en),
    .o_expired (tmo_expired)
  );

  // Receive FSM with registered pixel, bank and pulse outputs.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      hi_q         <= '0;
      pix_cnt_q    <= '0;
      pix_data_q   <= '0;
      pix_addr_q   <= '0;
      pix_valid_q  <= 1'b0;
      buf_sel_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      receiving_q  <= 1'b0;
    end else begin
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (i_rcv_flag && (i_rcv_data == SYNC_BYTE)) begin
            state_q     <= ST_RX_HI;
            pix_cnt_q   <= '0;
            receiving_q <= 1'b1;
          end
        end

        // Inside the pixel payload the sync value is ordinary data.
        ST_RX_HI: begin
          if (i_rcv_flag) begin
            hi_q    <= i_rcv_data[3:0];
            state_q <= ST_RX_LO;
          end else if (tmo_expired) begin
            state_q     <= ST_IDLE;
            receiving_q <= 1'b0;
            err_q       <= 1'b1;
          end
        end

        ST_RX_LO: begin
          if (i_rcv_flag) begin
            pix_data_q  <= pack_pixel(hi_q, i_rcv_data);
            pix_addr_q  <= pix_cnt_q;
            pix_valid_q <= 1'b1;
            pix_cnt_q   <= pix_cnt_q + ADDR_W'(1);
            state_q     <= (pix_cnt_q == LAST_ADDR) ? ST_WAIT_TAIL : ST_RX_HI;
          end else if (tmo_expired) begin
            state_q     <= ST_IDLE;
            receiving_q <= 1'b0;
            err_q       <= 1'b1;
          end
        end

        // Only a good trailer hands the freshly written bank to the display.
        ST_WAIT_TAIL: begin
          if (i_rcv_flag) begin
            state_q     <= ST_IDLE;
            receiving_q <= 1'b0;
            if (i_rcv_data == SYNC_BYTE) begin
              buf_sel_q    <= ~buf_sel_q;
              frame_done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (tmo_expired) begin
            state_q     <= ST_IDLE;
            receiving_q <= 1'b0;
            err_q       <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          receiving_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_pix_data   = pix_data_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_pix_addr   = pix_addr_q;
  assign o_buf_sel    = buf_sel_q;
  assign o_frame_done = frame_done_q;
  assign o_err        = err_q;
  assign o_receiving  = receiving_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_img_rx_ctrl.sv
// Self-checking bench for img_rx_ctrl with a frame-level reference model:
// bytes are counted from the sync header, pixels are byte pairs, and the
// byte after the last pixel is the trailer.
module tb_img_rx_ctrl;

  localparam int PIX_NUM     = 3;
  localparam int TIMEOUT_CYC = 100;

  logic        clk_sys;
  logic        rst_n;
  logic [7:0]  rcv_data;
  logic        rcv_flag;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic [14:0] pix_addr;
  logic        buf_sel;
  logic        frame_done;
  logic        err;
  logic        receiving;
  logic [3:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit          m_active;
  int          m_idx;
  int          m_idle;
  bit          m_bank;
  logic [7:0]  m_hi;
  logic [11:0] m_data;
  logic [14:0] m_addr;
  bit          e_valid;
  bit          e_done;
  bit          e_err;

  img_rx_ctrl #(
    .PIX_NUM     (PIX_NUM),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (8'h5A)
  ) dut (
    .i_clk_sys    (clk_sys),
    .i_rst_n      (rst_n),
    .i_rcv_data   (rcv_data),
    .i_rcv_flag   (rcv_flag),
    .o_pix_data   (pix_data),
    .o_pix_valid  (pix_valid),
    .o_pix_addr   (pix_addr),
    .o_buf_sel    (buf_sel),
    .o_frame_done (frame_done),
    .o_err        (err),
    .o_receiving  (receiving),
    .o_state      (state)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected debug state derived from where the model sits in the frame.
  function automatic logic [3:0] exp_state();
    if (!m_active)               return 4'd0;
    if (m_idx == 2 * PIX_NUM)    return 4'd3;
    if ((m_idx % 2) == 0)        return 4'd1;
    return 4'd2;
  endfunction

  task automatic check_outputs(input string ctx);
    check({ctx, ".pix_valid"},  {15'd0, pix_valid},  {15'd0, e_valid});
    check({ctx, ".frame_done"}, {15'd0, frame_done}, {15'd0, e_done});
    check({ctx, ".err"},        {15'd0, err},        {15'd0, e_err});
    check({ctx, ".state"},      {12'd0, state},      {12'd0, exp_state()});
    check({ctx, ".receiving"},  {15'd0, receiving},  {15'd0, m_active});
    check({ctx, ".buf_sel"},    {15'd0, buf_sel},    {15'd0, m_bank});
    check({ctx, ".pix_data"},   {4'd0, pix_data},    {4'd0, m_data});
    check({ctx, ".pix_addr"},   {1'b0, pix_addr},    {1'b0, m_addr});
  endtask

  task automatic model_reset();
    m_active = 0; m_idx = 0; m_idle = 0; m_bank = 0;
    m_hi = '0; m_data = '0; m_addr = '0;
    e_valid = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    e_valid = 0; e_done = 0; e_err = 0;
    m_idle  = 0;
    if (!m_active) begin
      if (b == 8'h5A) begin
        m_active = 1;
        m_idx    = 0;
      end
    end else if (m_idx == 2 * PIX_NUM) begin
      if (b == 8'h5A) begin
        m_bank = ~m_bank;
        e_done = 1;
      end else begin
        e_err = 1;
      end
      m_active = 0;
    end else begin
      if ((m_idx % 2) == 0) begin
        m_hi = b;
      end else begin
        m_data  = {m_hi[3:0], b};
        m_addr  = 15'(m_idx / 2);
        e_valid = 1;
      end
      m_idx++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_sys);
    rcv_flag = 1'b1;
    rcv_data = b;
    model_byte(b);
    @(posedge clk_sys);
    #1;
    check_outputs("byte");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      rcv_flag = 1'b0;
      rcv_data = 8'h00;
      e_valid = 0; e_done = 0; e_err = 0;
      if (m_active) begin
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin
          e_err    = 1;
          m_active = 0;
        end
      end
      @(posedge clk_sys);
      #1;
      check_outputs("idle");
    end
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rcv_flag = 1'b0;
    rst_n    = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] px_hi, input logic [7:0] px_lo,
                            input logic [7:0] trailer);
    send_byte(8'h5A);
    for (int p = 0; p < PIX_NUM; p++) begin
      send_byte(px_hi);
      send_byte(px_lo);
    end
    send_byte(trailer);
  endtask

  initial begin
    rst_n    = 1'b0;
    rcv_flag = 1'b0;
    rcv_data = 8'h00;
    model_reset();
    #12;
    check_outputs("por");
    do_reset();
    idle(2);

    // Clean frame of 12'h328 pixels, committed by the trailer.
    send_frame(8'h73, 8'h28, 8'h5A);
    idle(2);

    // Noise before sync is ignored; frame left open in RX_HI.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h5A);
    send_byte(8'h0F);
    send_byte(8'hFF);
    idle(1);
    check("open_state", {12'd0, state}, 16'd1);
    // Let it time out exactly.
    idle(TIMEOUT_CYC);

    // Sync value inside the payload is pixel data.
    send_frame(8'h5A, 8'h5A, 8'h5A);
    idle(1);

    // Bad trailer aborts without swapping the bank.
    send_frame(8'h12, 8'h34, 8'h00);
    idle(1);

    // Timeout after a lone hi byte.
    send_byte(8'h5A);
    send_byte(8'h73);
    idle(TIMEOUT_CYC);
    idle(3);

    // Byte arriving on the terminal-count cycle beats the timeout.
    send_byte(8'h5A);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'hC1);
    send_byte(8'h23);
    idle(TIMEOUT_CYC - 1);
    send_byte(8'h44);
    idle(TIMEOUT_CYC + 2);

    // Reset between hi and lo byte of pixel 1, then a full frame.
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    do_reset();
    send_frame(8'h0A, 8'hBC, 8'h5A);
    idle(1);
    check("post_reset_bank", {15'd0, buf_sel}, 16'd1);

    // Randomised frames with gaps, random trailers and line noise.
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        send_byte(8'($urandom_range(0, 255)));
      end
      send_byte(8'h5A);
      for (int b = 0; b < 2 * PIX_NUM; b++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 6)));
        send_byte(8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 255)));
      else                          send_byte(8'h5A);
      idle(int'($urandom_range(0, 3)) + 1);
    end
    idle(TIMEOUT_CYC + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
